// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM states, op codes and wait-counter width for data_mem_responder
package dmem_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_e;
  typedef enum logic {OP_RD, OP_WR} op_e;
  localparam int WAIT_CNT_W = 4;
endpackage

// File: rtl/dmem_wait_counter.sv
// dmem_wait_counter: loadable down-counter, done_o high once the count reaches zero
module dmem_wait_counter
  import dmem_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  en_i,
  input  logic [WAIT_CNT_W-1:0] load_val_i,
  output logic                  done_o
);
  logic [WAIT_CNT_W-1:0] cnt_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else if (load_i) cnt_q <= load_val_i;
    else if (en_i && !done_o) cnt_q <= cnt_q - 1'b1;
  assign done_o = cnt_q == '0;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated big-endian word memory on the DAddr/nRD/nWR bus; DMEM_BYTE_LANE_EN adds ByteEn write lanes
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] DAddr,
  input  logic [31:0] DataIn,
  input  logic        nRD,
  input  logic        nWR,
`ifdef DMEM_BYTE_LANE_EN
  input  logic [3:0]  ByteEn,
`endif
  output logic [31:0] Dataout,
  output logic        Ready,
  output logic        Err
);
  localparam logic [WAIT_CNT_W-1:0] LOAD_V = WAIT_CNT_W'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  state_e state_q, state_d;
  op_e op_q;
  logic [ADDR_W-3:0] addr_q;
  logic [31:0] data_q, dout_q, rd_word;
  logic err_q, accept, bad, cnt_done, commit;
  logic [3:0] be;
  logic [7:0] mem [2**ADDR_W];
  assign accept = state_q == S_IDLE && (!nRD || !nWR);
  assign bad = (!nRD && !nWR) || DAddr[1:0] != 2'b00 || (DAddr >> ADDR_W) != '0;
  assign commit = state_q == S_ACCESS && !err_q && op_q == OP_WR;
  assign rd_word = {mem[{addr_q, 2'd0}], mem[{addr_q, 2'd1}], mem[{addr_q, 2'd2}], mem[{addr_q, 2'd3}]};
  assign Dataout = dout_q;
  assign Ready = state_q == S_DONE;
  assign Err = Ready && err_q;
  dmem_wait_counter u_wait (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (accept),
    .en_i       (state_q == S_WAIT),
    .load_val_i (LOAD_V),
    .done_o     (cnt_done)
  );
  always_comb begin
    state_d = state_q;
    state_d = state_q == S_IDLE   ? (accept ? (WAIT_CYCLES == 0 ? S_ACCESS : S_WAIT) : S_IDLE) :
              state_q == S_WAIT   ? (cnt_done ? S_ACCESS : S_WAIT) :
              state_q == S_ACCESS ? S_DONE : S_IDLE;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= S_IDLE;
      op_q <= OP_RD;
      addr_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
      dout_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= nRD ? OP_WR : OP_RD;
        addr_q <= DAddr[ADDR_W-1:2];
        data_q <= DataIn;
        err_q <= bad;
      end
      if (state_q == S_ACCESS && (err_q || op_q == OP_RD)) dout_q <= err_q ? '0 : rd_word;
    end
`ifdef DMEM_BYTE_LANE_EN
  logic [3:0] be_q;
  always_ff @(posedge CLK or posedge RST)
    if (RST) be_q <= '0;
    else if (accept) be_q <= ByteEn;
  assign be = be_q;
`else
  assign be = 4'hF;
`endif
  // storage is never reset; bit 3 of be is the lowest byte address (MSB of the word)
  always_ff @(posedge CLK)
    for (int i = 0; i < 4; i++)
      if (commit && be[3-i]) mem[{addr_q, 2'(i)}] <= data_q[31-8*i -: 8];
endmodule
